spi_arbiter: RTL and testbench

Shares the single spi master between two requesters: requester 0 is the CPU-facing peripheral register path, requester 1 is the cartridge/ROM loader streaming from SPI flash. The block grants ownership round-robin, owns chip select for the owner, and sequences the spi master's start/busy handshake byte by byte. It sits between the requesters and the `spi` instance. It replaces direct driving of `spi_start_1`, `spi_tx_buffer_1`, `spi_divisor_1` and `spi_cs_1` by the peripheral register decode.

---
 rtl/spi_arb_pkg.sv | 19 +
 rtl/spi_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_spi_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OWN    = 3'd1,
    START  = 3'd2,
    XFER   = 3'd3,
    FINISH = 3'd4,
    GAP    = 3'd5
  } arb_state_t;

  localparam int unsigned CS_GAP_DEFAULT        = 4;
  localparam int unsigned START_TIMEOUT_DEFAULT = 64;

  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/spi_arbiter.sv
// Round-robin owner of the single SPI master: CPU register path (0) and
// cartridge/ROM loader (1). Owns chip select and the start/busy handshake.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned CS_GAP        = CS_GAP_DEFAULT,
  parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic       req_0,
  input  logic       req_1,
  input  logic       valid_0,
  input  logic       valid_1,
  input  logic [7:0] tx_0,
  input  logic [7:0] tx_1,
  input  logic [2:0] div_0,
  input  logic [2:0] div_1,
  output logic       grant_0,
  output logic       grant_1,
  output logic       done_0,
  output logic       done_1,
  output logic [7:0] rx_data,
  output logic       error,
  output logic       spi_start,
  output logic [7:0] spi_data_tx,
  output logic [2:0] spi_divisor,
  input  logic [7:0] spi_data_rx,
  input  logic       spi_busy,
  output logic       spi_cs
);

  // One counter serves both the CS gap and the start timeout.
  localparam int unsigned CNT_MAX = (CS_GAP > START_TIMEOUT) ? CS_GAP : START_TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  arb_state_t  state, state_n;
  logic        owner, owner_n;
  logic        last_owner, last_owner_n;
  logic [CW-1:0] cnt, cnt_n;

  logic        grant_0_n, grant_1_n;
  logic        done_0_n, done_1_n;
  logic        error_n;
  logic [7:0]  rx_data_n;
  logic        spi_start_n;
  logic [7:0]  spi_data_tx_n;
  logic [2:0]  spi_divisor_n;
  logic        spi_cs_n;

  logic        req_own, valid_own, done_n, pick;

  // Round-robin pick: on a tie the requester that did not own last wins.
  function automatic logic arb_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return !last;
    return r1 ? REQ_LOADER : REQ_CPU;
  endfunction

  // Next-state and next-output decode.
  always_comb begin
    state_n       = state;
    owner_n       = owner;
    last_owner_n  = last_owner;
    cnt_n         = cnt;
    grant_0_n     = grant_0;
    grant_1_n     = grant_1;
    error_n       = 1'b0;
    done_n        = 1'b0;
    rx_data_n     = rx_data;
    spi_start_n   = spi_start;
    spi_data_tx_n = spi_data_tx;
    spi_divisor_n = spi_divisor;
    spi_cs_n      = spi_cs;
    pick          = REQ_CPU;

    req_own   = (owner == REQ_LOADER) ? req_1   : req_0;
    valid_own = (owner == REQ_LOADER) ? valid_1 : valid_0;

    case (state)
      IDLE: begin
        if (req_0 || req_1) begin
          pick          = arb_pick(req_0, req_1, last_owner);
          owner_n       = pick;
          last_owner_n  = pick;
          spi_divisor_n = (pick == REQ_LOADER) ? div_1 : div_0;
          spi_cs_n      = 1'b0;
          grant_0_n     = (pick == REQ_CPU);
          grant_1_n     = (pick == REQ_LOADER);
          state_n       = OWN;
        end
      end
      OWN: begin
        if (valid_own) begin
          spi_data_tx_n = (owner == REQ_LOADER) ? tx_1 : tx_0;
          spi_start_n   = 1'b1;
          cnt_n         = '0;
          state_n       = START;
        end else if (!req_own) begin
          spi_cs_n  = 1'b1;
          grant_0_n = 1'b0;
          grant_1_n = 1'b0;
          cnt_n     = '0;
          state_n   = GAP;
        end
      end
      START: begin
        if (spi_busy) begin
          spi_start_n = 1'b0;
          state_n     = XFER;
        end else if (cnt == CW'(START_TIMEOUT - 1)) begin
          spi_start_n = 1'b0;
          done_n      = 1'b1;
          error_n     = 1'b1;
          state_n     = FINISH;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      XFER: begin
        if (!spi_busy) begin
          rx_data_n = spi_data_rx;
          done_n    = 1'b1;
          state_n   = FINISH;
        end
      end
      FINISH: begin
        if (req_own) begin
          state_n = OWN;
        end else begin
          spi_cs_n  = 1'b1;
          grant_0_n = 1'b0;
          grant_1_n = 1'b0;
          cnt_n     = '0;
          state_n   = GAP;
        end
      end
      GAP: begin
        if (cnt == CW'(CS_GAP - 1)) state_n = IDLE;
        else                        cnt_n   = cnt + CW'(1);
      end
      default: state_n = IDLE;
    endcase

    done_0_n = done_n && (owner == REQ_CPU);
    done_1_n = done_n && (owner == REQ_LOADER);
  end

  // State and registered outputs; reset drops CS/start on the next edge.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= REQ_CPU;
      last_owner  <= REQ_LOADER;
      cnt         <= '0;
      grant_0     <= 1'b0;
      grant_1     <= 1'b0;
      done_0      <= 1'b0;
      done_1      <= 1'b0;
      error       <= 1'b0;
      rx_data     <= '0;
      spi_start   <= 1'b0;
      spi_data_tx <= '0;
      spi_divisor <= '0;
      spi_cs      <= 1'b1;
    end else begin
      state       <= state_n;
      owner       <= owner_n;
      last_owner  <= last_owner_n;
      cnt         <= cnt_n;
      grant_0     <= grant_0_n;
      grant_1     <= grant_1_n;
      done_0      <= done_0_n;
      done_1      <= done_1_n;
      error       <= error_n;
      rx_data     <= rx_data_n;
      spi_start   <= spi_start_n;
      spi_data_tx <= spi_data_tx_n;
      spi_divisor <= spi_divisor_n;
      spi_cs      <= spi_cs_n;
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed scenarios plus randomized
// ownership/byte sequences checked against a transaction-level model.
module tb_spi_arbiter;

  localparam int unsigned CS_GAP        = 4;
  localparam int unsigned START_TIMEOUT = 64;

  logic       raw_clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_0 = 1'b0, req_1 = 1'b0;
  logic       valid_0 = 1'b0, valid_1 = 1'b0;
  logic [7:0] tx_0 = '0, tx_1 = '0;
  logic [2:0] div_0 = '0, div_1 = '0;
  logic       grant_0, grant_1, done_0, done_1, error;
  logic [7:0] rx_data;
  logic       spi_start;
  logic [7:0] spi_data_tx;
  logic [2:0] spi_divisor;
  logic [7:0] spi_data_rx = '0;
  logic       spi_busy = 1'b0;
  logic       spi_cs;

  spi_arbiter #(.CS_GAP(CS_GAP), .START_TIMEOUT(START_TIMEOUT)) dut (
    .raw_clk(raw_clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .valid_0(valid_0), .valid_1(valid_1),
    .tx_0(tx_0), .tx_1(tx_1), .div_0(div_0), .div_1(div_1),
    .grant_0(grant_0), .grant_1(grant_1), .done_0(done_0), .done_1(done_1),
    .rx_data(rx_data), .error(error), .spi_start(spi_start),
    .spi_data_tx(spi_data_tx), .spi_divisor(spi_divisor),
    .spi_data_rx(spi_data_rx), .spi_busy(spi_busy), .spi_cs(spi_cs)
  );

  always #5 raw_clk = ~raw_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural SPI master: latches the byte on start, raises busy after
  // sp_delay cycles, holds it sp_len cycles, then returns sp_reply.
  int unsigned sp_delay = 2, sp_len = 10, sp_phase = 0, sp_cnt = 0, sp_starts = 0;
  bit          sp_mute = 0;
  logic [7:0]  sp_reply = 8'h3C;
  logic [7:0]  sp_seen_tx = '0;

  always @(negedge raw_clk) begin
    case (sp_phase)
      0: if (spi_start && !sp_mute) begin
           sp_seen_tx = spi_data_tx;
           sp_starts++;
           sp_cnt   = sp_delay;
           sp_phase = 1;
         end
      1: if (sp_cnt == 0) begin
           spi_busy = 1'b1;
           sp_cnt   = sp_len;
           sp_phase = 2;
         end else sp_cnt--;
      default: if (sp_cnt <= 1) begin
           spi_busy    = 1'b0;
           spi_data_rx = sp_reply;
           sp_phase    = 0;
         end else sp_cnt--;
    endcase
  end

  // Reference state kept at transaction level.
  logic       last = 1'b1;
  logic [7:0] rx_hold = '0;
  int unsigned cs_hi_cnt = 0, g0_cnt = 0, d1_cnt = 0;

  task automatic tick();
    @(posedge raw_clk);
    #1;
    if (spi_cs) cs_hi_cnt++;
    if (grant_0) g0_cnt++;
    if (done_1) d1_cnt++;
    check_eq("cs_vs_grant", spi_cs, !(grant_0 || grant_1));
    check_eq("grant_excl", grant_0 && grant_1, 0);
    check_eq("error_only_with_done", error && !(done_0 || done_1), 0);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return done_0;
      1: return done_1;
      2: return grant_0;
      3: return grant_1;
      default: return spi_busy;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int unsigned limit, input string tag);
    int unsigned n = 0;
    while (!sig(sel) && n < limit) begin
      tick();
      n++;
    end
    check_eq(tag, sig(sel), 1);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_0 = 1'b0; req_1 = 1'b0; valid_0 = 1'b0; valid_1 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    last = 1'b1;
    rx_hold = '0;
  endtask

  // Send one byte as the current owner and check its completion.
  task automatic do_byte(input logic who, input logic [7:0] tx, input bit exp_err);
    int unsigned start_hi = 0;
    int unsigned waited = 0;
    int unsigned starts0 = sp_starts;
    logic got = 1'b0;
    if (who) begin tx_1 = tx; valid_1 = 1'b1; end
    else     begin tx_0 = tx; valid_0 = 1'b1; end
    tick();
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    check_eq("start_rise", spi_start, 1);
    check_eq("tx_latch", spi_data_tx, tx);
    while (!got && waited < 300) begin
      if (spi_start) start_hi++;
      tick();
      waited++;
      got = who ? done_1 : done_0;
    end
    check_eq("done_seen", got, 1);
    if (got) begin
      check_eq("done_other", who ? done_0 : done_1, 0);
      check_eq("error", error, exp_err);
      check_eq("start_len", start_hi, exp_err ? START_TIMEOUT : sp_delay + 2);
      check_eq("spi_start_low", spi_start, 0);
      if (!exp_err) begin
        rx_hold = sp_reply;
        check_eq("spi_saw_tx", sp_seen_tx, tx);
        check_eq("spi_one_start", sp_starts, starts0 + 1);
      end
      check_eq("rx_data", rx_data, rx_hold);
    end
    tick();
    check_eq("done_pulse", done_0 || done_1, 0);
    check_eq("error_clear", error, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        win;
    int unsigned pat, nb, n_cs, s0;

    // Reset values
    do_reset();
    reset = 1'b1;
    tick();
    check_eq("rst_cs", spi_cs, 1);
    check_eq("rst_start", spi_start, 0);
    check_eq("rst_grants", {grant_0, grant_1}, 0);
    check_eq("rst_dones", {done_0, done_1}, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_rx", rx_data, 0);
    check_eq("rst_tx", spi_data_tx, 0);
    check_eq("rst_div", spi_divisor, 0);
    reset = 1'b0;
    tick();

    // Single byte
    req_0 = 1'b1; div_0 = 3'd3;
    tick();
    check_eq("single_grant", grant_0, 1);
    check_eq("single_cs", spi_cs, 0);
    check_eq("single_div", spi_divisor, 3);
    sp_delay = 2; sp_len = 10; sp_reply = 8'h3C;
    do_byte(1'b0, 8'hA5, 1'b0);
    check_eq("single_rx", rx_data, 8'h3C);
    req_0 = 1'b0;
    idle(8);
    check_eq("single_release", grant_0, 0);

    // Tie after reset: requester 0 first, then 1 after the CS gap
    do_reset();
    req_0 = 1'b1; req_1 = 1'b1;
    tick();
    check_eq("tie1_g0", grant_0, 1);
    check_eq("tie1_g1", grant_1, 0);
    sp_reply = 8'h5E;
    do_byte(1'b0, 8'h11, 1'b0);
    req_0 = 1'b0;
    n_cs = 0;
    for (int unsigned i = 0; i < 40 && !grant_1; i++) begin
      tick();
      if (spi_cs) n_cs++;
    end
    check_eq("tie1_then_g1", grant_1, 1);
    check_eq("tie1_cs_gap", n_cs, CS_GAP + 1);
    req_1 = 1'b0;
    idle(10);
    req_0 = 1'b1; req_1 = 1'b1;
    tick();
    check_eq("tie2_g0", grant_0, 1);
    req_0 = 1'b0;
    wait_sig(3, 40, "tie2_then_g1");
    check_eq("tie2_g0_off", grant_0, 0);
    req_1 = 1'b0;
    idle(10);
    last = 1'b1;

    // Burst from requester 1 while requester 0 waits
    req_1 = 1'b1; div_1 = 3'd5;
    tick();
    check_eq("burst_grant", grant_1, 1);
    check_eq("burst_div", spi_divisor, 5);
    req_0 = 1'b1;
    cs_hi_cnt = 0; g0_cnt = 0; d1_cnt = 0;
    sp_reply = 8'hC1; do_byte(1'b1, 8'h03, 1'b0);
    sp_reply = 8'h2D; do_byte(1'b1, 8'h00, 1'b0);
    sp_reply = 8'h99; do_byte(1'b1, 8'h10, 1'b0);
    check_eq("burst_cs_low", cs_hi_cnt, 0);
    check_eq("burst_no_g0", g0_cnt, 0);
    check_eq("burst_dones", d1_cnt, 3);
    req_1 = 1'b0;
    wait_sig(2, 40, "burst_then_g0");
    req_0 = 1'b0;
    idle(10);

    // Start timeout
    req_0 = 1'b1;
    tick();
    check_eq("to_grant", grant_0, 1);
    sp_mute = 1;
    do_byte(1'b0, 8'h77, 1'b1);
    sp_mute = 0;
    req_0 = 1'b0;
    idle(10);

    // Intrusion: non-owner valid and mid-byte valid are ignored
    req_0 = 1'b1;
    tick();
    check_eq("intr_grant", grant_0, 1);
    s0 = sp_starts;
    tx_1 = 8'hEE; valid_1 = 1'b1;
    tick();
    valid_1 = 1'b0;
    check_eq("intr_v1_start", spi_start, 0);
    check_eq("intr_v1_g1", grant_1, 0);
    sp_reply = 8'h6B;
    tx_0 = 8'h5A; valid_0 = 1'b1;
    tick();
    valid_0 = 1'b0;
    wait_sig(4, 40, "intr_busy");
    tick();
    tx_0 = 8'hC3; valid_0 = 1'b1; valid_1 = 1'b1;
    tick();
    valid_0 = 1'b0; valid_1 = 1'b0;
    check_eq("intr_tx_kept", spi_data_tx, 8'h5A);
    wait_sig(0, 60, "intr_done");
    check_eq("intr_rx", rx_data, 8'h6B);
    rx_hold = 8'h6B;
    idle(4);
    check_eq("intr_no_restart", spi_start, 0);
    check_eq("intr_starts", sp_starts, s0 + 1);
    check_eq("intr_tx_final", spi_data_tx, 8'h5A);
    req_0 = 1'b0;
    idle(10);

    // Reset in the middle of a transfer
    req_0 = 1'b1;
    tick();
    sp_len = 12;
    tx_0 = 8'h42; valid_0 = 1'b1;
    tick();
    valid_0 = 1'b0;
    wait_sig(4, 40, "rst_mid_busy");
    tick();
    reset = 1'b1;
    req_0 = 1'b0;
    tick();
    check_eq("rmid_cs", spi_cs, 1);
    check_eq("rmid_start", spi_start, 0);
    check_eq("rmid_grants", {grant_0, grant_1}, 0);
    reset = 1'b0;
    last = 1'b1;
    rx_hold = '0;
    for (int unsigned i = 0; i < 40 && spi_busy; i++) tick();
    idle(2);
    req_1 = 1'b1;
    tick();
    check_eq("rmid_regrant", grant_1, 1);
    sp_len = 4; sp_reply = 8'hB7;
    do_byte(1'b1, 8'h24, 1'b0);
    req_1 = 1'b0;
    idle(10);

    // Randomized ownership and bytes against the transaction model
    for (int unsigned it = 0; it < 30; it++) begin
      pat   = $urandom_range(1, 3);
      div_0 = 3'($urandom);
      div_1 = 3'($urandom);
      req_0 = pat[0];
      req_1 = pat[1];
      win   = (pat == 3) ? !last : (pat == 2);
      tick();
      check_eq("rnd_grant0", grant_0, !win);
      check_eq("rnd_grant1", grant_1, win);
      check_eq("rnd_div", spi_divisor, win ? div_1 : div_0);
      last = win;
      nb = $urandom_range(1, 3);
      for (int unsigned b = 0; b < nb; b++) begin
        sp_delay = $urandom_range(0, 3);
        sp_len   = $urandom_range(1, 12);
        sp_mute  = ($urandom_range(0, 7) == 0);
        sp_reply = 8'($urandom);
        do_byte(win, 8'($urandom), sp_mute);
        sp_mute = 0;
      end
      if (win) req_1 = 1'b0;
      else     req_0 = 1'b0;
      if (pat == 3) begin
        wait_sig(win ? 2 : 3, 40, "rnd_rr_next");
        check_eq("rnd_rr_div", spi_divisor, win ? div_0 : div_1);
        last = !win;
        req_0 = 1'b0;
        req_1 = 1'b0;
      end
      idle(CS_GAP + 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
